// File: rtl/xip_flash_pkg.sv
// Shared types and constants for the XIP serial flash model.
package xip_flash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } xip_state_e;

    localparam logic [7:0]  OPC_READ      = 8'h03;
    localparam logic [7:0]  OPC_FAST_READ = 8'h0B;
    localparam int unsigned ADDR_BITS     = 24;
    localparam int unsigned DUMMY_BITS    = 8;

endpackage

// File: rtl/xip_flash_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module xip_flash_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw input along the chain; keep the last synced level for edge detection
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history flops
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Synchronized level and single-cycle edge strobes
    always_comb begin
        q    = sync_q[STAGES-1];
        rise = q & ~prev_q;
        fall = ~q & prev_q;
    end

endmodule

// File: rtl/xip_flash_model.sv
// SPI mode-0 serial flash read model with a byte-wide preload port.
// Optional: define XIP_FAST_READ_EN to accept the 0x0B fast-read opcode
// (8 dummy clocks between address and data).
module xip_flash_model
    import xip_flash_pkg::*;
#(
    parameter int unsigned MEM_AW      = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              spi_csn,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_we,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              cmd_err
);

    logic csn_s, csn_rise, csn_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    xip_flash_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk  (clk),
        .arst (arst),
        .d    (spi_csn),
        .q    (csn_s),
        .rise (csn_rise),
        .fall (csn_fall)
    );

    xip_flash_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .arst (arst),
        .d    (spi_sck),
        .q    (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    xip_flash_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .arst (arst),
        .d    (spi_mosi),
        .q    (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // Only edges of csn/sck and the level of mosi drive the logic
    assign unused_edges = ^{csn_s, sck_s, mosi_rise, mosi_fall};

    xip_state_e        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              load_q, load_d;
    logic              fast_q, fast_d;
    logic              cmd_err_q, cmd_err_d;

    // Preload storage; not reset so contents survive arst
    logic [7:0] mem_q [0:(1<<MEM_AW)-1];

    logic [7:0] opcode;
    logic       opc_read, opc_fast, opc_ok;

    assign opcode   = {shift_q, mosi_s};
    assign opc_read = (opcode == OPC_READ);
`ifdef XIP_FAST_READ_EN
    assign opc_fast = (opcode == OPC_FAST_READ);
`else
    assign opc_fast = 1'b0;
`endif
    assign opc_ok   = opc_read | opc_fast;

    // Preload write port
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            load_q    <= 1'b0;
            fast_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            load_q    <= load_d;
            fast_q    <= fast_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Next-state logic; a csn rise aborts from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (csn_fall) state_d = StCmd;
            end
            StCmd: begin
                if (sck_rise && bit_cnt_q == 5'd7) state_d = opc_ok ? StAddr : StIgnore;
            end
            StAddr: begin
                if (sck_rise && bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                    state_d = fast_q ? StDummy : StData;
                end
            end
            StDummy: begin
                if (sck_rise && bit_cnt_q == 5'(DUMMY_BITS - 1)) state_d = StData;
            end
            StData:   state_d = StData;
            StIgnore: state_d = StIgnore;
            default:  state_d = StIdle;
        endcase
        if (csn_rise) state_d = StIdle;
    end

    // Datapath: shift in opcode/address, shift out data on sck falls, prefetch bytes
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        load_d    = 1'b0;
        fast_d    = fast_q;
        cmd_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                fast_d    = 1'b0;
                miso_d    = 1'b0;
            end
            StCmd: begin
                if (sck_rise) begin
                    shift_d = opcode[6:0];
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        fast_d    = opc_fast;
                        cmd_err_d = ~opc_ok;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StAddr: begin
                if (sck_rise) begin
                    // Upper address bits fall off the top of the register
                    addr_d = {addr_q[MEM_AW-2:0], mosi_s};
                    if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                        bit_cnt_d = '0;
                        load_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StDummy: begin
                if (sck_rise) begin
                    bit_cnt_d = (bit_cnt_q == 5'(DUMMY_BITS - 1)) ? 5'd0 : bit_cnt_q + 5'd1;
                end
            end
            StData: begin
                if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                        load_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase
        // Registered read sees pre-write contents when load_we hits the same address
        if (load_q) tx_d = mem_q[addr_q];
        if (csn_rise) begin
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            load_d    = 1'b0;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy        = (state_q == StCmd) || (state_q == StAddr) ||
                      (state_q == StDummy) || (state_q == StData);
        spi_miso_oe = (state_q == StData);
        spi_miso    = spi_miso_oe & miso_q;
        cmd_err     = cmd_err_q;
    end

endmodule
